// File: rtl/seq_multiplier_32_if.sv
// Request/response bundle between the execute-stage control and the
// sequential multiplier.
interface seq_multiplier_32_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               flush;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, flush, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/seq_multiplier_32.sv
// Radix-2 shift-add unsigned multiplier; all additions are done by an
// external adder whose operands are driven from here each RUN cycle.
module seq_multiplier_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_32_if.slave bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] result_q;
    logic               in_run;

    assign in_run     = (state == RUN);
    assign bus.busy   = (state == RUN) || (state == DONE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

    assign add_a   = in_run ? p[2*WIDTH-1:WIDTH] : '0;
    assign add_b   = (in_run && p[0]) ? m : '0;
    assign add_cin = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            m        <= '0;
            p        <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m     <= bus.op_a;
                        p     <= {{WIDTH{1'b0}}, bus.op_b};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Carry lands in the top bit, so the product never overflows.
                    p   <= {add_cout, add_sum, p[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result_q <= {add_cout, add_sum, p[WIDTH-1:1]};
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier_32.sv
// Directed bench for seq_multiplier_32 with a behavioural external adder.
module tb_seq_multiplier_32;
    logic        clk;
    logic        rst_n;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    int          passed;
    int          total;

    seq_multiplier_32_if bus ();

    seq_multiplier_32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output int done_edge,
                          output int done_cnt, output logic [31:0] b_or,
                          output logic cin_or);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        tick();
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_edge = -1;
        b_or      = '0;
        cin_or    = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_edge = k - 1;
            end
            if (bus.busy && !bus.done) b_or = b_or | add_b;
            cin_or = cin_or | add_cin;
            tick();
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
        else passed++;
        total++;
        if (bus.result !== 64'd0)
            $display("FAIL reset_result got=%h want 0", bus.result);
        else passed++;
        total++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0)
            $display("FAIL reset_adder a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
        else passed++;
    endtask

    task automatic test_basic();
        int bc, de, dc;
        logic [31:0] bo;
        logic co;
        run_op(32'd3, 32'd5, bc, de, dc, bo, co);
        total++;
        if (bc != 33) $display("FAIL basic_busy_cycles got=%0d want 33", bc);
        else passed++;
        total++;
        if (de != 32 || dc != 1)
            $display("FAIL basic_done edge=%0d count=%0d want 32 1", de, dc);
        else passed++;
        total++;
        if (bus.result !== 64'd15)
            $display("FAIL basic_result got=%h want 15", bus.result);
        else passed++;
        total++;
        if (co !== 1'b0) $display("FAIL basic_cin got=%b want 0", co);
        else passed++;
    endtask

    task automatic test_max();
        int bc, de, dc;
        logic [31:0] bo;
        logic co;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, bc, de, dc, bo, co);
        total++;
        if (bus.result !== 64'hFFFFFFFE_00000001)
            $display("FAIL max_result got=%h want fffffffe00000001", bus.result);
        else passed++;
        total++;
        if (de != 32) $display("FAIL max_done_edge got=%0d want 32", de);
        else passed++;
    endtask

    task automatic test_zero_b();
        int bc, de, dc;
        logic [31:0] bo;
        logic co;
        run_op(32'h12345678, 32'd0, bc, de, dc, bo, co);
        total++;
        if (bus.result !== 64'd0)
            $display("FAIL zero_result got=%h want 0", bus.result);
        else passed++;
        total++;
        if (bo !== 32'd0) $display("FAIL zero_add_b got=%h want 0", bo);
        else passed++;
    endtask

    task automatic test_busy_start();
        int e;
        int bc, de, dc;
        logic [31:0] bo;
        logic co;
        bus.start = 1'b1;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        tick();
        bus.start = 1'b0;
        e = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            e++;
        end
        bus.start = 1'b1;
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd9;
        tick();
        e++;
        bus.start = 1'b0;
        for (int k = 0; k < 40 && !bus.done; k++) begin
            tick();
            e++;
        end
        total++;
        if (!bus.done || e != 32)
            $display("FAIL busy_start_done done=%b edge=%0d want 1 32", bus.done, e);
        else passed++;
        total++;
        if (bus.result !== 64'd15)
            $display("FAIL busy_start_result got=%h want 15", bus.result);
        else passed++;
        tick();
        tick();
        run_op(32'd7, 32'd9, bc, de, dc, bo, co);
        total++;
        if (bus.result !== 64'd63)
            $display("FAIL seq_result got=%h want 63", bus.result);
        else passed++;
    endtask

    task automatic test_flush();
        int seen;
        bus.start = 1'b1;
        bus.op_a  = 32'd11;
        bus.op_b  = 32'd13;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL flush_idle busy=%b done=%b want 0 0", bus.busy, bus.done);
        else passed++;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) seen++;
            tick();
        end
        total++;
        if (seen != 0) $display("FAIL flush_no_done got=%0d want 0", seen);
        else passed++;
        total++;
        if (bus.result !== 64'd63)
            $display("FAIL flush_result got=%h want 63", bus.result);
        else passed++;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op_a  = 32'd2;
        bus.op_b  = 32'd3;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        tick();
        total++;
        if (bus.busy !== 1'b0)
            $display("FAIL start_flush_idle busy=%b want 0", bus.busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int bc, de, dc;
        logic [31:0] bo;
        logic co;
        bus.start = 1'b1;
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd9;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'd0)
            $display("FAIL reset_mid busy=%b done=%b result=%h want 0 0 0",
                     bus.busy, bus.done, bus.result);
        else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_op(32'h80000000, 32'd2, bc, de, dc, bo, co);
        total++;
        if (bus.result !== 64'h1_00000000 || dc != 1)
            $display("FAIL after_reset_result got=%h done=%0d want 100000000 1",
                     bus.result, dc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int dc;
        int de [2];
        dc = 0;
        de[0] = -1;
        de[1] = -1;
        bus.start = 1'b1;
        bus.op_a  = 32'd6;
        bus.op_b  = 32'd7;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (bus.done) begin
                if (dc < 2) de[dc] = k;
                dc++;
            end
        end
        bus.start = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        total++;
        if (dc != 2 || de[0] != 32 || de[1] != 66)
            $display("FAIL back_to_back count=%0d edges=%0d,%0d want 2 32,66",
                     dc, de[0], de[1]);
        else passed++;
        total++;
        if (bus.result !== 64'd42)
            $display("FAIL back_to_back_result got=%h want 42", bus.result);
        else passed++;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        #12;
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_max();
        test_zero_b();
        test_busy_start();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
